// File: rtl/xras_sla_pkg.sv
// Shared types and constants for the XRAS SLA escalation engine and its level trackers.
package xras_sla_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [7:0] {
    ACTIVE   = 8'd0,
    WARNING  = 8'd1,
    BREACHED = 8'd2
  } sla_status_e;

  localparam logic [7:0] LVL_DEVICE = 8'd0;
  localparam logic [7:0] LVL_EDGE   = 8'd1;
  localparam logic [7:0] LVL_ACCESS = 8'd2;
  localparam logic [7:0] LVL_METRO  = 8'd3;
  localparam logic [7:0] LVL_CORE   = 8'd4;
  localparam logic [7:0] LVL_CLOUD  = 8'd5;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    WATCH    = 2'd1,
    PENDING  = 2'd2,
    COOLDOWN = 2'd3
  } tracker_state_e;

  // breach_cnt is sized by the default counter width; the top casts to its CNT_W.
  typedef struct packed {
    logic [7:0]           level;
    logic [31:0]          sla_id;
    logic [31:0]          worst_gap;
    logic [CNT_W_DEF-1:0] breach_cnt;
  } esc_payload_t;

endpackage

// File: rtl/xras_sla_level_tracker.sv
// Per-level debounce FSM: warn/breach run counters, worst gap of the breach run,
// latched threshold sla_id and post-escalation cooldown timer.
module xras_sla_level_tracker
  import xras_sla_pkg::*;
#(
  parameter int WARN_THRESH     = 4,
  parameter int BREACH_THRESH   = 2,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_vld,
  input  logic [7:0]       sla_status,
  input  logic [31:0]      gap,
  input  logic [31:0]      sla_id,
  input  logic             release_evt,
  output tracker_state_e   state,
  output logic             pending,
  output logic             in_watch,
  output logic [31:0]      held_id,
  output logic [31:0]      worst_gap,
  output logic [CNT_W-1:0] breach_cnt
);

  localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);

  tracker_state_e   state_nxt;
  logic [CNT_W-1:0] warn_cnt, warn_nxt, breach_nxt, warn_inc, breach_inc;
  logic [31:0]      gap_nxt, id_nxt, gap_max;
  logic [CD_W-1:0]  cd_cnt, cd_nxt;

  assign warn_inc   = (warn_cnt == '1) ? warn_cnt : warn_cnt + 1'b1;
  assign breach_inc = (breach_cnt == '1) ? breach_cnt : breach_cnt + 1'b1;
  assign gap_max    = (gap > worst_gap) ? gap : worst_gap;
  assign pending    = (state == PENDING);
  assign in_watch   = (state == WATCH);

  always_comb begin
    state_nxt  = state;
    warn_nxt   = warn_cnt;
    breach_nxt = breach_cnt;
    gap_nxt    = worst_gap;
    id_nxt     = held_id;
    cd_nxt     = cd_cnt;
    case (state)
      OK, WATCH: begin
        if (sample_vld) begin
          if (sla_status == ACTIVE) begin
            state_nxt  = OK;
            warn_nxt   = '0;
            breach_nxt = '0;
            gap_nxt    = '0;
          end else if (sla_status == WARNING) begin
            // A warning ends any breach run but keeps the OK/WATCH state.
            warn_nxt   = warn_inc;
            breach_nxt = '0;
            gap_nxt    = '0;
            if (state == OK && warn_inc == CNT_W'(WARN_THRESH)) state_nxt = WATCH;
          end else begin
            warn_nxt   = '0;
            breach_nxt = breach_inc;
            gap_nxt    = gap_max;
            if (breach_inc == CNT_W'(BREACH_THRESH)) begin
              state_nxt = PENDING;
              id_nxt    = sla_id;
            end
          end
        end
      end
      PENDING: begin
        if (sample_vld) gap_nxt = gap_max;
        if (release_evt) begin
          state_nxt = COOLDOWN;
          cd_nxt    = CD_W'(COOLDOWN_CYCLES);
        end
      end
      COOLDOWN: begin
        if (cd_cnt == '0) begin
          state_nxt  = OK;
          warn_nxt   = '0;
          breach_nxt = '0;
          gap_nxt    = '0;
        end else begin
          cd_nxt = cd_cnt - 1'b1;
        end
      end
      default: state_nxt = OK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OK;
      warn_cnt   <= '0;
      breach_cnt <= '0;
      worst_gap  <= '0;
      held_id    <= '0;
      cd_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      warn_cnt   <= warn_nxt;
      breach_cnt <= breach_nxt;
      worst_gap  <= gap_nxt;
      held_id    <= id_nxt;
      cd_cnt     <= cd_nxt;
    end
  end

endmodule

// File: rtl/xras_sla_escalation_engine.sv
// Routes SLA samples to per-level trackers and arbitrates escalations onto a valid/ready port.
// Optional unacknowledged-event timeout: define XRAS_SLA_ESC_TIMEOUT_EN.
module xras_sla_escalation_engine
  import xras_sla_pkg::*;
#(
  parameter int NUM_LEVELS      = 6,
  parameter int WARN_THRESH     = 4,
  parameter int BREACH_THRESH   = 2,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           sla_id,
  input  logic [31:0]           current_reliability,
  input  logic [31:0]           reliability_gap,
  input  logic [7:0]            sla_status,
  input  logic                  sla_updated,
  output logic                  esc_valid,
  input  logic                  esc_ready,
  output logic [7:0]            esc_level,
  output logic [31:0]           esc_sla_id,
  output logic [31:0]           esc_worst_gap,
  output logic [CNT_W-1:0]      esc_breach_cnt,
  output logic [NUM_LEVELS-1:0] watch_mask,
  output logic [15:0]           drop_cnt,
  output logic                  esc_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: the payload is presented while esc_valid is high and must not change
  // until esc_valid && esc_ready is seen on a rising clock edge (or the timeout fires).
  logic [7:0]            level;
  logic                  in_range, fire, to_hit, pick_vld;
  logic [NUM_LEVELS-1:0] trk_pending, trk_release, cand;
  tracker_state_e        trk_state [NUM_LEVELS];
  logic [31:0]           trk_id    [NUM_LEVELS];
  logic [31:0]           trk_gap   [NUM_LEVELS];
  logic [CNT_W-1:0]      trk_bcnt  [NUM_LEVELS];
  esc_payload_t          pay_q, pick_pay;
  logic                  unused_reliability;

  assign unused_reliability = ^current_reliability;
  assign level    = sla_id[31:24];
  assign in_range = level < 8'(NUM_LEVELS);
  assign fire     = esc_valid && esc_ready;

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_trk
    assign trk_release[g] = (fire || to_hit) && (pay_q.level == 8'(g));

    xras_sla_level_tracker #(
      .WARN_THRESH    (WARN_THRESH),
      .BREACH_THRESH  (BREACH_THRESH),
      .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
      .CNT_W          (CNT_W)
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .sample_vld (sla_updated && in_range && (level == 8'(g))),
      .sla_status (sla_status),
      .gap        (reliability_gap),
      .sla_id     (sla_id),
      .release_evt(trk_release[g]),
      .state      (trk_state[g]),
      .pending    (trk_pending[g]),
      .in_watch   (watch_mask[g]),
      .held_id    (trk_id[g]),
      .worst_gap  (trk_gap[g]),
      .breach_cnt (trk_bcnt[g])
    );
  end

  // The presented level is still PENDING until its release edge, so it is masked
  // out; the highest remaining index wins.
  always_comb begin
    cand     = trk_pending;
    pick_vld = 1'b0;
    pick_pay = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (esc_valid && pay_q.level == 8'(i)) cand[i] = 1'b0;
      if (cand[i]) begin
        pick_vld            = 1'b1;
        pick_pay.level      = 8'(i);
        pick_pay.sla_id     = trk_id[i];
        pick_pay.worst_gap  = trk_gap[i];
        pick_pay.breach_cnt = CNT_W_DEF'(trk_bcnt[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      esc_valid <= 1'b0;
      pay_q     <= '0;
    end else if (to_hit) begin
      esc_valid <= 1'b0;
    end else if (!esc_valid || fire) begin
      esc_valid <= pick_vld;
      if (pick_vld) pay_q <= pick_pay;
    end
  end

  assign esc_level      = pay_q.level;
  assign esc_sla_id     = pay_q.sla_id;
  assign esc_worst_gap  = pay_q.worst_gap;
  assign esc_breach_cnt = CNT_W'(pay_q.breach_cnt);

  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (sla_updated && !in_range && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end

`ifdef XRAS_SLA_ESC_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign to_hit = esc_valid && !esc_ready && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts stalled cycles of the current presentation; loads and handshakes restart it.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      esc_timeout <= 1'b0;
    end else begin
      if (!esc_valid || esc_ready || to_hit) to_cnt <= '0;
      else to_cnt <= to_cnt + 1'b1;
      if (to_hit) esc_timeout <= 1'b1;
    end
  end
`else
  logic [TO_W-1:0] unused_to_cnt;

  assign unused_to_cnt = '0;
  assign to_hit        = 1'b0;
  assign esc_timeout   = 1'b0;
`endif

endmodule
